// File: rtl/effective_address_unit.sv
// PDP-8 memory-reference effective-address generator.
// Forms the direct address, fetches indirect pointers and
// optionally performs auto-index write-back through the
// memory_controller request/done handshake.
// Ports: clk, reset (async, active-high), start, instruction,
//   pc -> busy, done, ea; mem_* drive/observe memory_controller.
// Option: define AUTOINDEX_EN to enable auto-index (0o0010-0o0017).
module effective_address_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] instruction,
  input  logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ea,
  output logic [ADDR_W-1:0] mem_address,
  output logic [ADDR_W-1:0] mem_write_data,
  output logic              mem_read_enable,
  output logic              mem_read_type,
  output logic              mem_write_enable,
  input  logic [ADDR_W-1:0] mem_read_data,
  input  logic              mem_operation_done
);

  localparam logic DATA_READ = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RD_REQ,
    S_RD_WAIT,
`ifdef AUTOINDEX_EN
    S_WR_REQ,
    S_WR_WAIT,
`endif
    S_DONE
  } state_t;

  state_t      r_state;
  logic [8:0]  r_instr;
  logic [4:0]  r_page;
  logic        r_op_q;

  logic [ADDR_W-1:0] w_da;
  logic              w_rise;
  logic              w_unused;

  // Only I, Z, OFF and the pc page take part in addressing.
  assign w_unused = ^{instruction[ADDR_W-1:9], pc[6:0]};

  assign w_da = r_instr[7]
              ? {r_page, r_instr[6:0]}
              : {{(ADDR_W-7){1'b0}}, r_instr[6:0]};

  // Memory completion is a rising edge, not a level.
  assign w_rise = mem_operation_done & ~r_op_q;

  assign busy          = (r_state != S_IDLE);
  assign mem_read_type = DATA_READ;

`ifdef AUTOINDEX_EN
  logic w_auto;
  logic [ADDR_W-1:0] r_wdata;
  logic              r_wen;

  // DA in 0o0010..0o0017; Z=1 pages outside page 0 never match.
  assign w_auto = (w_da[ADDR_W-1:3] == 9'd1);

  assign mem_write_data   = r_wdata;
  assign mem_write_enable = r_wen;
`else
  assign mem_write_data   = '0;
  assign mem_write_enable = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_instr         <= '0;
      r_page          <= '0;
      r_op_q          <= 1'b0;
      done            <= 1'b0;
      ea              <= '0;
      mem_address     <= '0;
      mem_read_enable <= 1'b0;
`ifdef AUTOINDEX_EN
      r_wdata         <= '0;
      r_wen           <= 1'b0;
`endif
    end else begin
      r_op_q          <= mem_operation_done;
      done            <= 1'b0;
      mem_read_enable <= 1'b0;
`ifdef AUTOINDEX_EN
      r_wen           <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_instr <= instruction[8:0];
            r_page  <= pc[ADDR_W-1:7];
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!r_instr[8]) begin
            ea      <= w_da;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            mem_address     <= w_da;
            mem_read_enable <= 1'b1;
            r_state         <= S_RD_REQ;
          end
        end
        S_RD_REQ: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (w_rise) begin
`ifdef AUTOINDEX_EN
            if (w_auto) begin
              r_wdata <= mem_read_data + ADDR_W'(1);
              r_wen   <= 1'b1;
              r_state <= S_WR_REQ;
            end else begin
              ea      <= mem_read_data;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
`else
            ea      <= mem_read_data;
            done    <= 1'b1;
            r_state <= S_DONE;
`endif
          end
        end
`ifdef AUTOINDEX_EN
        S_WR_REQ: r_state <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (w_rise) begin
            ea      <= r_wdata;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_effective_address_unit.sv
// Self-checking bench for effective_address_unit with a
// behavioural memory_controller and an EA reference model.
module tb_effective_address_unit;

`ifdef AUTOINDEX_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] instruction = '0;
  logic [11:0] pc = '0;
  logic        busy, done;
  logic [11:0] ea, mem_address, mem_write_data;
  logic        mem_read_enable, mem_read_type, mem_write_enable;
  logic [11:0] mem_read_data = '0;
  logic        mem_operation_done = 1'b0;

  effective_address_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .instruction(instruction),
    .pc(pc),
    .busy(busy),
    .done(done),
    .ea(ea),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_enable(mem_read_enable),
    .mem_read_type(mem_read_type),
    .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data),
    .mem_operation_done(mem_operation_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] mem [0:4095];
  int          lat = 0;
  logic        pend_wr = 1'b0;
  logic [11:0] pend_addr = '0;
  logic [11:0] pend_data = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [11:0] poke_data = '0;

  logic        exp_pending = 1'b0;
  logic [11:0] exp_ea = '0;
  logic        rtype_ref = 1'b0;
  int          done_seen = 0;

  task automatic chk(input string name,
                     input logic [11:0] act,
                     input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %o, expected %o", name, act, exp);
    end
  endtask

  // Memory controller model: 3-cycle latency, one-cycle done.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lat <= 0;
      mem_operation_done <= 1'b0;
    end else begin
      mem_operation_done <= 1'b0;
      if (poke_en) mem[poke_addr] <= poke_data;
      if (lat > 0) begin
        lat <= lat - 1;
        if (lat == 1) begin
          mem_operation_done <= 1'b1;
          if (pend_wr) mem[pend_addr] <= pend_data;
          else mem_read_data <= mem[pend_addr];
        end
      end
      if (mem_read_enable) begin
        lat <= 3;
        pend_wr <= 1'b0;
        pend_addr <= mem_address;
        rd_cnt <= rd_cnt + 1;
      end
      if (mem_write_enable) begin
        lat <= 3;
        pend_wr <= 1'b1;
        pend_addr <= mem_address;
        pend_data <= mem_write_data;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  // Reference: address arithmetic straight from the PDP-8 rules.
  function automatic int model_da(input logic [11:0] ins,
                                  input logic [11:0] p);
    int page;
    page = ins[7] ? (int'(p) / 128) * 128 : 0;
    return page + (int'(ins) % 128);
  endfunction

  function automatic logic [11:0] model_ea(input logic [11:0] ins,
                                           input logic [11:0] p);
    int da, ptr;
    da = model_da(ins, p);
    if (!ins[8]) return da[11:0];
    ptr = int'(mem[da]);
    if (AUTO && da >= 8 && da <= 15) ptr = (ptr + 1) % 4096;
    return ptr[11:0];
  endfunction

  // Compare process: every done must be expected and match model.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read_enable || mem_write_enable)
        chk("enable_overlap",
            {11'b0, mem_read_enable & mem_write_enable}, 12'd0);
      if (mem_read_enable)
        chk("read_type", {11'b0, mem_read_type}, {11'b0, rtype_ref});
      if (done) begin
        done_seen++;
        chk("spurious_done", {11'b0, exp_pending}, 12'd1);
        if (exp_pending) chk("ea_model", ea, exp_ea);
      end
    end
  end

  task automatic poke(input logic [11:0] a, input logic [11:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic run_op(input string nm,
                        input logic [11:0] ins,
                        input logic [11:0] p,
                        input logic [11:0] lit,
                        input bit extra);
    int k, rdk, wrk, mk1, mk, r0, w0, d0, da;
    bit got;
    logic [11:0] m;
    int xr, xw;
    m = model_ea(ins, p);
    chk({nm, "_lit"}, m, lit);
    da = model_da(ins, p);
    xr = ins[8] ? 1 : 0;
    xw = (ins[8] && AUTO && da >= 8 && da <= 15) ? 1 : 0;
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_seen;
    exp_ea = m;
    @(posedge clk); #1;
    instruction = ins; pc = p; start = 1'b1; exp_pending = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; got = 0; rdk = -1; wrk = -1; mk1 = -1; mk = -1;
    while (k < 60 && !got) begin
      @(negedge clk);
      k++;
      if (mem_read_enable && rdk < 0) rdk = k;
      if (mem_write_enable && wrk < 0) wrk = k;
      if (mem_operation_done) begin
        if (mk1 < 0) mk1 = k;
        mk = k;
      end
      if (done) got = 1;
      if (extra && k == 2) begin
        start = 1'b1; instruction = 12'o0177;
      end
      if (extra && k == 3) start = 1'b0;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, {11'b0, got}, 12'd1);
    if (got) begin
      if (!ins[8]) begin
        chk({nm, "_lat"}, 12'(k), 12'd2);
      end else begin
        chk({nm, "_rd_cyc"}, 12'(rdk), 12'd2);
        chk({nm, "_lat"}, 12'(k), 12'(mk + 1));
        if (xw == 1) chk({nm, "_wr_cyc"}, 12'(wrk), 12'(mk1 + 1));
      end
      chk({nm, "_ea"}, ea, lit);
    end
    chk({nm, "_reads"}, 12'(rd_cnt - r0), 12'(xr));
    chk({nm, "_writes"}, 12'(wr_cnt - w0), 12'(xw));
    if (xr == 1) chk({nm, "_addr"}, mem_address, 12'(da));
    @(posedge clk); #1;
    exp_pending = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_after"}, {11'b0, busy}, 12'd0);
    repeat (6) @(negedge clk);
    chk({nm, "_done_count"}, 12'(done_seen - d0), 12'd1);
  endtask

  initial begin
    int k;
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_busy", {11'b0, busy}, 12'd0);
    chk("rst_done", {11'b0, done}, 12'd0);
    chk("rst_ea", ea, 12'd0);
    chk("rst_addr", mem_address, 12'd0);
    chk("rst_wdata", mem_write_data, 12'd0);
    chk("rst_ren", {11'b0, mem_read_enable}, 12'd0);
    chk("rst_wen", {11'b0, mem_write_enable}, 12'd0);
    rtype_ref = mem_read_type;
    @(posedge clk); #1;
    reset = 1'b0;

    poke(12'o0034, 12'o5000);
    poke(12'o0010, 12'o0777);
    poke(12'o0017, 12'o7777);
    poke(12'o0410, 12'o1234);

    run_op("cur_page", 12'o1234, 12'o0200, 12'o0234, 0);
    run_op("page_zero", 12'o1034, 12'o4600, 12'o0034, 0);
    run_op("indirect", 12'o1434, 12'o4600, 12'o5000, 0);
    run_op("autoidx", 12'o1410, 12'o0200,
           AUTO ? 12'o1000 : 12'o0777, 0);
    chk("m0010_readback", mem[8], AUTO ? 12'o1000 : 12'o0777);
    run_op("wrap", 12'o1417, 12'o0200,
           AUTO ? 12'o0000 : 12'o7777, 0);
    chk("m0017_readback", mem[15], AUTO ? 12'o0000 : 12'o7777);
    run_op("zpage_410", 12'o1610, 12'o0400, 12'o1234, 1);
    run_op("busy_start", 12'o1434, 12'o0000, 12'o5000, 1);

    // Reset while waiting for the read to complete.
    @(posedge clk); #1;
    instruction = 12'o1434; pc = 12'o0000;
    start = 1'b1; exp_pending = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 20 && !mem_read_enable) begin
      @(negedge clk);
      k++;
    end
    chk("rr_read_seen", {11'b0, mem_read_enable}, 12'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rr_busy", {11'b0, busy}, 12'd0);
    chk("rr_done", {11'b0, done}, 12'd0);
    chk("rr_ren", {11'b0, mem_read_enable}, 12'd0);
    chk("rr_wen", {11'b0, mem_write_enable}, 12'd0);
    chk("rr_ea", ea, 12'd0);
    exp_pending = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rr_ea_after", ea, 12'd0);
    run_op("after_rst", 12'o1434, 12'o0000, 12'o5000, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
